fifo_split: RTL and testbench

Width-downsizing FIFO that accepts 16-bit words and emits them as 8-bit bytes. It is the companion of the 8→16 packing FIFO and uses the same valid/enable handshake on both sides. Upstream logic hands it packed 16-bit words, and a byte-wide consumer drains them. Storage is a small circular buffer of words, plus a byte-select bit that tracks which half of the head word is presented.

---
 rtl/fifo_split.sv | 98 +++++++++
 tb/tb_fifo_split.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fifo_split.sv
// Width-downsizing FIFO: stores 16-bit words and presents them as 8-bit bytes, low byte first.
// Defining FIFO_SPLIT_MSB_FIRST_EN switches the presentation order to high byte first.
module fifo_split #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        input_valid,
  output logic        input_enable,
  input  logic [15:0] data_in,
  output logic        output_valid,
  input  logic        output_enable,
  output logic [7:0]  data_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          half_r;

  logic          push_s;
  logic          pop_s;
  logic          retire_s;
  logic [15:0]   head_s;
  logic [CW-1:0] count_nxt_s;

  assign input_enable = (count_r != CW'(DEPTH));
  assign output_valid = (count_r != {CW{1'b0}});
  assign push_s       = input_valid && input_enable;
  assign pop_s        = output_valid && output_enable;
  assign retire_s     = pop_s && half_r;
  assign head_s       = mem_r[rd_ptr_r];

  // Occupancy update for every push/retire combination
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, retire_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and byte-select registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      half_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (retire_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (pop_s) begin
        half_r <= ~half_r;
      end
    end
  end

  // Word storage; contents are left intact by reset and simply become unreachable
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Byte mux on the head word, forced to zero while empty
  always_comb begin
    data_out = 8'h00;
    if (!output_valid) begin
      data_out = 8'h00;
    end else begin
`ifdef FIFO_SPLIT_MSB_FIRST_EN
      if (half_r) begin
        data_out = head_s[7:0];
      end else begin
        data_out = head_s[15:8];
      end
`else
      if (half_r) begin
        data_out = head_s[15:8];
      end else begin
        data_out = head_s[7:0];
      end
`endif
    end
  end

endmodule

// File: tb/tb_fifo_split.sv
// Self-checking bench for fifo_split: vector table for fill/drain plus hand-written
// corner sequences, with a byte scoreboard checking every cycle.
module tb_fifo_split;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        input_valid;
  logic        input_enable;
  logic [15:0] data_in;
  logic        output_valid;
  logic        output_enable;
  logic [7:0]  data_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  fifo_split #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .input_valid   (input_valid),
    .input_enable  (input_enable),
    .data_in       (data_in),
    .output_valid  (output_valid),
    .output_enable (output_enable),
    .data_out      (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] din;
    logic        oe;
    logic        exp_ie;
    logic        exp_ov;
    logic [15:0] exp_word;
    logic        exp_half;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [7:0] byte_of(input logic [15:0] w, input logic h);
`ifdef FIFO_SPLIT_MSB_FIRST_EN
    return h ? w[7:0] : w[15:8];
`else
    return h ? w[15:8] : w[7:0];
`endif
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check against the scoreboard mid-cycle, advance past the edge.
  task automatic cycle(input logic r, input logic iv, input logic [15:0] d, input logic oe);
    logic model_ov;
    logic model_ie;
    rst = r; input_valid = iv; data_in = d; output_enable = oe;
    @(negedge clk);
    if (r) begin
      sb_q.delete();
    end else begin
      model_ov = (sb_q.size() != 0);
      model_ie = (((sb_q.size() + 1) / 2) < DEPTH);
      chk("sb_output_valid", {15'd0, output_valid}, {15'd0, model_ov});
      chk("sb_input_enable", {15'd0, input_enable}, {15'd0, model_ie});
      if (model_ov) begin
        chk("sb_data_out", {8'd0, data_out}, {8'd0, sb_q[0]});
        if (oe) void'(sb_q.pop_front());
      end else begin
        chk("sb_empty_data_out", {8'd0, data_out}, 16'h0000);
      end
      if (iv && model_ie) begin
        sb_q.push_back(byte_of(d, 1'b0));
        sb_q.push_back(byte_of(d, 1'b1));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("drain_ov", {15'd0, output_valid}, 16'h0000);
    chk("drain_sb_empty", 16'(sb_q.size()), 16'h0000);
  endtask

  initial begin
    rst = 1'b1; input_valid = 1'b0; data_in = 16'h0000; output_enable = 1'b0;

    // Reset for two edges with a word offered
    cycle(1'b1, 1'b1, 16'h1111, 1'b0);
    cycle(1'b1, 1'b1, 16'h1111, 1'b0);
    chk("reset_ie", {15'd0, input_enable}, 16'h0001);
    chk("reset_ov", {15'd0, output_valid}, 16'h0000);
    chk("reset_dout", {8'd0, data_out}, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("reset_nothing_stored", {15'd0, output_valid}, 16'h0000);

    // Single word
    cycle(1'b0, 1'b1, 16'hA55A, 1'b0);
    chk("single_first", {8'd0, data_out}, {8'd0, byte_of(16'hA55A, 1'b0)});
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("single_second", {8'd0, data_out}, {8'd0, byte_of(16'hA55A, 1'b1)});
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("single_empty_ov", {15'd0, output_valid}, 16'h0000);

    // Fill to full, attempt a fifth word, then drain
    vecs[0]  = '{1'b1, 16'h0102, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 16'h0304, 1'b0, 1'b1, 1'b1, 16'h0102, 1'b0};
    vecs[2]  = '{1'b1, 16'h0506, 1'b0, 1'b1, 1'b1, 16'h0102, 1'b0};
    vecs[3]  = '{1'b1, 16'h0708, 1'b0, 1'b1, 1'b1, 16'h0102, 1'b0};
    vecs[4]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0102, 1'b0};
    vecs[5]  = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0102, 1'b0};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0102, 1'b1};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0304, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0304, 1'b1};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0506, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0506, 1'b1};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0708, 1'b0};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0708, 1'b1};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("vec%0d_ie", i), {15'd0, input_enable}, {15'd0, vecs[i].exp_ie});
      chk($sformatf("vec%0d_ov", i), {15'd0, output_valid}, {15'd0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_dout", i), {8'd0, data_out},
          vecs[i].exp_ov ? {8'd0, byte_of(vecs[i].exp_word, vecs[i].exp_half)} : 16'h0000);
      cycle(1'b0, vecs[i].iv, vecs[i].din, vecs[i].oe);
    end

    // Full with half consumed, retire and push on the following edge
    cycle(1'b0, 1'b1, 16'h1112, 1'b0);
    cycle(1'b0, 1'b1, 16'h2122, 1'b0);
    cycle(1'b0, 1'b1, 16'h3132, 1'b0);
    cycle(1'b0, 1'b1, 16'h4142, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("full_half_ie", {15'd0, input_enable}, 16'h0000);
    cycle(1'b0, 1'b1, 16'hBEEF, 1'b1);
    chk("retire_ie_rise", {15'd0, input_enable}, 16'h0001);
    cycle(1'b0, 1'b1, 16'hBEEF, 1'b1);
    chk("push_pop_full_again", {15'd0, input_enable}, 16'h0000);
    chk("beef_last", {8'd0, sb_q[sb_q.size()-1]}, {8'd0, byte_of(16'hBEEF, 1'b1)});
    drain();

    // Stall mid-word
    cycle(1'b0, 1'b1, 16'h1234, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_dout", {8'd0, data_out}, {8'd0, byte_of(16'h1234, 1'b1)});
      chk("stall_ov", {15'd0, output_valid}, 16'h0001);
      cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    drain();

    // Reset mid-word discards the remaining bytes
    cycle(1'b0, 1'b1, 16'h1234, 1'b0);
    cycle(1'b0, 1'b1, 16'h5678, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("midreset_ov", {15'd0, output_valid}, 16'h0000);
    chk("midreset_dout", {8'd0, data_out}, 16'h0000);
    chk("midreset_ie", {15'd0, input_enable}, 16'h0001);
    cycle(1'b0, 1'b1, 16'h9ABC, 1'b0);
    chk("after_reset_first", {8'd0, data_out}, {8'd0, byte_of(16'h9ABC, 1'b0)});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
